// File: rtl/mips_hazard_sb_if.sv
// Decode-stage request and pipeline-control bundle between the hazard unit
// and the controller/datapath; master drives Decode info, slave drives control.
interface mips_hazard_sb_if #(
  parameter int REGBITS   = 5,
  parameter int CNT_WIDTH = 16
);
  logic [REGBITS-1:0]   RsD;
  logic [REGBITS-1:0]   RtD;
  logic [REGBITS-1:0]   WriteRegD;
  logic                 RegWriteD;
  logic                 MemtoRegD;
  logic                 BranchD;
  logic                 JrD;
  logic                 MdStartD;
  logic                 MdReadD;
  logic                 StallF;
  logic                 StallD;
  logic                 FlushE;
  logic                 ForwardAD;
  logic                 ForwardBD;
  logic [1:0]           ForwardAE;
  logic [1:0]           ForwardBE;
  logic                 MdBusy;
  logic [CNT_WIDTH-1:0] StallCount;

  modport master (
    output RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD, JrD, MdStartD, MdReadD,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MdBusy, StallCount
  );

  modport slave (
    input  RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD, JrD, MdStartD, MdReadD,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MdBusy, StallCount
  );
endinterface

// File: rtl/mips_hazard_sb.sv
// Stateful hazard unit: shadow E/M/W tag pipeline, forward selects, load/branch/
// mult-div interlocks and a saturating stall-cycle counter. Outputs are combinational.
module mips_hazard_sb #(
  parameter int REGBITS    = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            reset,
  mips_hazard_sb_if.slave hz
);
  localparam int MDW = $clog2(MD_LATENCY + 1);

  typedef logic [REGBITS-1:0] reg_t;
  typedef struct packed {
    logic rw;
    logic m2r;
    reg_t wr;
  } tag_t;
  typedef struct packed {
    tag_t t;
    reg_t rs;
    reg_t rt;
  } etag_t;
  // W's MemtoReg has no consumer in this unit, so W keeps only the write tag.
  typedef struct packed {
    logic rw;
    reg_t wr;
  } wtag_t;

  etag_t          e_q, e_d;
  tag_t           m_q;
  wtag_t          w_q;
  logic [MDW-1:0] mdcnt_q, mdcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic rsd_e, rtd_e, rsd_m, rtd_m;
  logic lwstall, brstall, mdstall, stall, md_busy;

  function automatic logic hit(input logic rw, input reg_t wr, input reg_t src);
    return rw && (src != '0) && (wr == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input tag_t m, input wtag_t w, input reg_t src);
    if (hit(m.rw, m.wr, src))      return 2'b10;
    else if (hit(w.rw, w.wr, src)) return 2'b01;
    else                           return 2'b00;
  endfunction

  assign rsd_e = hit(e_q.t.rw, e_q.t.wr, hz.RsD);
  assign rtd_e = hit(e_q.t.rw, e_q.t.wr, hz.RtD);
  assign rsd_m = hit(m_q.rw, m_q.wr, hz.RsD);
  assign rtd_m = hit(m_q.rw, m_q.wr, hz.RtD);

  assign md_busy = (mdcnt_q != '0);
  assign lwstall = e_q.t.m2r && (rsd_e || rtd_e);
  // jr only reads Rs; beq/bne compare both sources in Decode.
  assign brstall = (hz.BranchD || hz.JrD) &&
                   (rsd_e || (hz.BranchD && rtd_e) ||
                    (m_q.m2r && rsd_m) || (hz.BranchD && m_q.m2r && rtd_m));
  assign mdstall = (hz.MdStartD || hz.MdReadD) && md_busy;
  assign stall   = lwstall || brstall || mdstall;

  assign hz.StallF     = stall;
  assign hz.StallD     = stall;
  assign hz.FlushE     = stall;
  assign hz.ForwardAD  = rsd_m;
  assign hz.ForwardBD  = rtd_m;
  assign hz.ForwardAE  = fwd_sel(m_q, w_q, e_q.rs);
  assign hz.ForwardBE  = fwd_sel(m_q, w_q, e_q.rt);
  assign hz.MdBusy     = md_busy;
  assign hz.StallCount = cnt_q;

  always_comb begin
    e_d     = '0;
    mdcnt_d = mdcnt_q;
    cnt_d   = cnt_q;

    if (!stall) begin
      e_d.t.rw  = hz.RegWriteD;
      e_d.t.m2r = hz.MemtoRegD;
      e_d.t.wr  = hz.WriteRegD;
      e_d.rs    = hz.RsD;
      e_d.rt    = hz.RtD;
    end

    if (hz.MdStartD && !stall) begin
      mdcnt_d = MDW'(MD_LATENCY - 1);
    end else if (md_busy) begin
      mdcnt_d = mdcnt_q - MDW'(1);
    end

    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      mdcnt_q <= '0;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      m_q     <= e_q.t;
      w_q.rw  <= m_q.rw;
      w_q.wr  <= m_q.wr;
      mdcnt_q <= mdcnt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mips_hazard_sb.sv
// Directed-vector bench for mips_hazard_sb built with MD_LATENCY=4, CNT_WIDTH=2.
module tb_mips_hazard_sb;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  mips_hazard_sb_if #(.REGBITS(5), .CNT_WIDTH(2)) hz ();

  mips_hazard_sb #(.REGBITS(5), .MD_LATENCY(4), .CNT_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one Decode instruction for a cycle; leaves time to sample before the next edge.
  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                     input logic rw, input logic m2r, input logic br, input logic jr,
                     input logic mds, input logic mdr);
    @(negedge clk);
    hz.RsD       = rs;
    hz.RtD       = rt;
    hz.WriteRegD = wr;
    hz.RegWriteD = rw;
    hz.MemtoRegD = m2r;
    hz.BranchD   = br;
    hz.JrD       = jr;
    hz.MdStartD  = mds;
    hz.MdReadD   = mdr;
    #2;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, ".StallF"}, {31'd0, hz.StallF}, {31'd0, exp});
    check({tag, ".StallD"}, {31'd0, hz.StallD}, {31'd0, exp});
    check({tag, ".FlushE"}, {31'd0, hz.FlushE}, {31'd0, exp});
  endtask

  initial begin
    hz.RsD = '0; hz.RtD = '0; hz.WriteRegD = '0;
    hz.RegWriteD = 1'b0; hz.MemtoRegD = 1'b0; hz.BranchD = 1'b0;
    hz.JrD = 1'b0; hz.MdStartD = 1'b0; hz.MdReadD = 1'b0;

    // Reset state: every output 0
    #2;
    check_stall("rst", 1'b0);
    check("rst.FwdAE", {30'd0, hz.ForwardAE}, 32'd0);
    check("rst.FwdBE", {30'd0, hz.ForwardBE}, 32'd0);
    check("rst.FwdAD", {31'd0, hz.ForwardAD}, 32'd0);
    check("rst.MdBusy", {31'd0, hz.MdBusy}, 32'd0);
    check("rst.cnt", {30'd0, hz.StallCount}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: lw $2 then add $3,$2,$1 -> one stall, then W forward
    do_reset();
    drv(5'd0, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_stall("t1.lw", 1'b0);
    drv(5'd2, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_stall("t1.use", 1'b1);
    drv(5'd2, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_stall("t1.retry", 1'b0);
    check("t1.cnt", {30'd0, hz.StallCount}, 32'd1);
    idle();
    check("t1.FwdAE", {30'd0, hz.ForwardAE}, 32'd1);
    check("t1.FwdBE", {30'd0, hz.ForwardBE}, 32'd0);

    // 2: back-to-back ALU dependency -> M forward; with a gap -> W forward
    do_reset();
    drv(5'd1, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(5'd4, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_stall("t2.sub", 1'b0);
    idle();
    check("t2.FwdAE.M", {30'd0, hz.ForwardAE}, 32'd2);
    check("t2.FwdBE.M", {30'd0, hz.ForwardBE}, 32'd2);
    do_reset();
    drv(5'd1, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    drv(5'd4, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("t2.FwdAE.W", {30'd0, hz.ForwardAE}, 32'd1);
    check("t2.FwdBE.W", {30'd0, hz.ForwardBE}, 32'd1);

    // 3: beq after lw $6 -> two stalls, then regfile read
    do_reset();
    drv(5'd0, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stall("t3.beqE", 1'b1);
    drv(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stall("t3.beqM", 1'b1);
    drv(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stall("t3.beqW", 1'b0);
    check("t3.FwdAD.W", {31'd0, hz.ForwardAD}, 32'd0);
    check("t3.cnt", {30'd0, hz.StallCount}, 32'd2);
    // beq after add $6 with one gap -> forward from M, no stall
    do_reset();
    drv(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    drv(5'd6, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stall("t3.add", 1'b0);
    check("t3.FwdAD", {31'd0, hz.ForwardAD}, 32'd1);
    check("t3.FwdBD", {31'd0, hz.ForwardBD}, 32'd0);
    // jr ignores RtD, but stalls on RsD produced in E
    do_reset();
    drv(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(5'd7, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_stall("t3.jrRt", 1'b0);
    do_reset();
    drv(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_stall("t3.jrRs", 1'b1);

    // 4: register-0 writes in E, M and W never hit
    do_reset();
    drv(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_stall("t4.lw0", 1'b0);
    drv(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stall("t4.beq0", 1'b0);
    check("t4.FwdAE", {30'd0, hz.ForwardAE}, 32'd0);
    check("t4.FwdBE", {30'd0, hz.ForwardBE}, 32'd0);
    check("t4.FwdAD", {31'd0, hz.ForwardAD}, 32'd0);
    check("t4.FwdBD", {31'd0, hz.ForwardBD}, 32'd0);

    // 5: mult then mflo with latency 4 -> three stalled cycles
    do_reset();
    drv(5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_stall("t5.mult", 1'b0);
    check("t5.busy0", {31'd0, hz.MdBusy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drv(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_stall($sformatf("t5.mflo%0d", i), 1'b1);
      check($sformatf("t5.busy%0d", i + 1), {31'd0, hz.MdBusy}, 32'd1);
    end
    drv(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_stall("t5.mfloOk", 1'b0);
    check("t5.busyEnd", {31'd0, hz.MdBusy}, 32'd0);
    check("t5.cnt", {30'd0, hz.StallCount}, 32'd3);
    drv(5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_stall("t5.mult2", 1'b0);
    idle();
    check("t5.busyAgain", {31'd0, hz.MdBusy}, 32'd1);

    // 6: five stall cycles saturate a 2-bit counter; async reset mid-stall
    do_reset();
    drv(5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      drv(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drv(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6.cnt3", {30'd0, hz.StallCount}, 32'd3);
    drv(5'd0, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stall("t6.st4", 1'b1);
    drv(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stall("t6.st5", 1'b1);
    check("t6.sat", {30'd0, hz.StallCount}, 32'd3);
    reset = 1'b1;
    #1;
    check_stall("t6.rst", 1'b0);
    check("t6.rstCnt", {30'd0, hz.StallCount}, 32'd0);
    check("t6.rstFwdAD", {31'd0, hz.ForwardAD}, 32'd0);
    check("t6.rstBusy", {31'd0, hz.MdBusy}, 32'd0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
